// File: rtl/aes_128_pkg.sv
// aes_128_pkg: types and widths shared by the aes_128 core, its arbiter and their benches
package aes_128_pkg;
  localparam int AES_BLOCK_W = 128;
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} aes_arb_state_t;
endpackage

// File: rtl/aes_128_arbiter_if.sv
// aes_128_arbiter_if: requester/response side of the shared aes_128 arbiter
interface aes_128_arbiter_if #(parameter int NUM_REQ = 4);
  import aes_128_pkg::*;
  localparam int ID_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*AES_BLOCK_W-1:0] req_in_bus;
  logic [NUM_REQ*AES_BLOCK_W-1:0] req_key;
  logic resp_valid;
  logic resp_ready;
  logic [ID_W-1:0] resp_id;
  logic [AES_BLOCK_W-1:0] resp_data;
  modport master(
    output req_valid, req_in_bus, req_key, resp_ready,
    input req_ready, resp_valid, resp_id, resp_data
  );
  modport slave(
    input req_valid, req_in_bus, req_key, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/aes_128_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr, wrapping
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_id
);
  logic [W-1:0] idx;
  // scanning from the far end lets the closest request to ptr overwrite the rest
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = W'((int'(ptr) + k) % N);
      if (en && req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
        gnt_id = idx;
      end
    end
  end
endmodule

// File: rtl/aes_128_arbiter.sv
// aes_128_arbiter: shares one multicycle aes_128 core among NUM_REQ requesters,
// one block in flight, ciphertext returned through a back-pressured response register
module aes_128_arbiter
  import aes_128_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  aes_128_arbiter_if.slave       bus,
  output logic [AES_BLOCK_W-1:0] core_in_bus,
  output logic [AES_BLOCK_W-1:0] core_key,
  input  logic                   core_ready,
  input  logic                   core_valid,
  input  logic [AES_BLOCK_W-1:0] core_out_bus,
  output logic                   err_timeout
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);
  aes_arb_state_t state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] owner;
  logic [ID_W-1:0] gnt_id;
  logic [NUM_REQ-1:0] gnt;
  logic [CNT_W-1:0] cnt;
  logic grant;
  // rst_n gates the grant so no combinational accept leaks out while in reset
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req(bus.req_valid),
    .ptr(ptr),
    .en(rst_n && state == IDLE && core_ready),
    .gnt(gnt),
    .gnt_id(gnt_id)
  );
  assign grant = |gnt;
  assign bus.req_ready = gnt;
  assign core_in_bus = grant ? bus.req_in_bus[gnt_id*AES_BLOCK_W +: AES_BLOCK_W] : '0;
  assign core_key = grant ? bus.req_key[gnt_id*AES_BLOCK_W +: AES_BLOCK_W] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      cnt <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_id <= '0;
      bus.resp_data <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      case (state)
        IDLE: if (grant) begin
          owner <= gnt_id;
          ptr <= (gnt_id == ID_LAST) ? '0 : gnt_id + 1'b1;
          cnt <= '0;
          state <= BUSY;
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (core_valid) begin
            bus.resp_data <= core_out_bus;
            bus.resp_id <= owner;
            bus.resp_valid <= 1'b1;
            state <= HOLD;
          end else if (cnt == CNT_LAST) begin
            err_timeout <= 1'b1;
            state <= IDLE;
          end
        end
        HOLD: if (bus.resp_ready) begin
          bus.resp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
